// File: rtl/reg_file.sv
// 32 x 32 integer register file: two combinational read ports, one write port.
// Entry 0 reads as zero; a pending write bypasses to the read ports.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_num1,
  output logic [DATA_W-1:0] read_res1,
  input  logic [ADDR_W-1:0] read_num2,
  output logic [DATA_W-1:0] read_res2,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_num,
  input  logic [DATA_W-1:0] write_res
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_go;
  logic              byp1;
  logic              byp2;

  assign wr_go = write_en && (write_num != '0);

  // Slot 0 is cleared on reset and never written, so it folds to constant zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_go) begin
      regs[write_num] <= write_res;
    end
  end

  assign byp1 = write_en && !rst && (write_num == read_num1);
  assign byp2 = write_en && !rst && (write_num == read_num2);

  always_comb begin
    read_res1 = regs[read_num1];
    if (read_num1 == '0) begin
      read_res1 = '0;
    end else if (byp1) begin
      read_res1 = write_res;
    end
  end

  always_comb begin
    read_res2 = regs[read_num2];
    if (read_num2 == '0) begin
      read_res2 = '0;
    end else if (byp2) begin
      read_res2 = write_res;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;

  logic        clk;
  logic        run;
  logic        rst;
  logic [4:0]  read_num1;
  logic [31:0] read_res1;
  logic [4:0]  read_num2;
  logic [31:0] read_res2;
  logic        write_en;
  logic [4:0]  write_num;
  logic [31:0] write_res;

  int errors;
  int checks;

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .read_num1 (read_num1),
    .read_res1 (read_res1),
    .read_num2 (read_num2),
    .read_res2 (read_res2),
    .write_en  (write_en),
    .write_num (write_num),
    .write_res (write_res)
  );

  // Clock only toggles while run is set, so reset can be pulsed with clk idle.
  always begin
    #5;
    if (run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] n, input logic [31:0] d);
    @(negedge clk);
    write_en  = 1'b1;
    write_num = n;
    write_res = d;
    @(posedge clk);
    #1;
    write_en  = 1'b0;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    clk       = 1'b0;
    run       = 1'b0;
    rst       = 1'b0;
    read_num1 = '0;
    read_num2 = '0;
    write_en  = 1'b0;
    write_num = '0;
    write_res = '0;

    // Reset pulse with the clock idle.
    #3;
    rst = 1'b1;
    #2;
    read_num1 = 5'd17;
    #1;
    check("rst_during_r1", read_res1, 32'h0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      read_num1 = 5'(i);
      #1;
      check($sformatf("rst_r1[%0d]", i), read_res1, 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      read_num2 = 5'(i);
      #1;
      check($sformatf("rst_r2[%0d]", i), read_res2, 32'h0);
    end

    run = 1'b1;

    // Write i to every index and read it back on port 2.
    for (int i = 0; i < 32; i++) begin
      write_reg(5'(i), 32'(i));
      read_num2 = 5'(i);
      #1;
      check($sformatf("sweep_r2[%0d]", i), read_res2, 32'(i));
    end

    // Index 0 discards writes, before and after the edge.
    @(negedge clk);
    write_en  = 1'b1;
    write_num = 5'd0;
    write_res = 32'hDEADBEEF;
    read_num1 = 5'd0;
    read_num2 = 5'd0;
    #1;
    check("zero_pre_r1", read_res1, 32'h0);
    check("zero_pre_r2", read_res2, 32'h0);
    @(posedge clk);
    #1;
    write_en = 1'b0;
    #1;
    check("zero_post_r1", read_res1, 32'h0);
    check("zero_post_r2", read_res2, 32'h0);

    // Bypass on port 1, storage on port 2.
    @(negedge clk);
    write_en  = 1'b1;
    write_num = 5'd7;
    write_res = 32'h12345678;
    read_num1 = 5'd7;
    read_num2 = 5'd8;
    #1;
    check("byp_r1", read_res1, 32'h12345678);
    check("byp_other_r2", read_res2, 32'h8);
    @(posedge clk);
    #1;
    write_en = 1'b0;
    #1;
    check("byp_stored_r1", read_res1, 32'h12345678);

    // Write disable with matching index, then dual read.
    write_reg(5'd3, 32'hA5A5A5A5);
    @(negedge clk);
    write_en  = 1'b0;
    write_num = 5'd3;
    write_res = 32'h0;
    read_num1 = 5'd3;
    read_num2 = 5'd3;
    #1;
    check("wdis_pre_r1", read_res1, 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    check("wdis_r1", read_res1, 32'hA5A5A5A5);
    check("wdis_r2", read_res2, 32'hA5A5A5A5);

    // Fill 1..31 with nonzero data.
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'hC000_0000 | 32'(i));
    end
    read_num1 = 5'd31;
    read_num2 = 5'd12;
    #1;
    check("fill_r1", read_res1, 32'hC000_001F);
    check("fill_r2", read_res2, 32'hC000_000C);

    // Async reset between edges, with a write attempted while held.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_r1", read_res1, 32'h0);
    check("arst_r2", read_res2, 32'h0);
    write_en  = 1'b1;
    write_num = 5'd5;
    write_res = 32'h55555555;
    read_num1 = 5'd5;
    #1;
    check("arst_nobyp_r1", read_res1, 32'h0);
    @(posedge clk);
    @(negedge clk);
    write_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_w5_r1", read_res1, 32'h0);
    for (int i = 1; i < 32; i++) begin
      read_num2 = 5'(i);
      #0.1;
      check($sformatf("arst_clr_r2[%0d]", i), read_res2, 32'h0);
    end

    // First write after release lands normally.
    write_reg(5'd9, 32'h00000099);
    read_num1 = 5'd9;
    #1;
    check("post_rst_w9", read_res1, 32'h00000099);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
